// File: rtl/uart_rx.sv
// uart_rx: 8-bit LSB-first UART receiver with optional parity, feeding the
// LC3 memory-mapped receive data/status registers.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   rxd          serial line (asynchronous, idle high)
//   parity_en    1 = a parity bit follows the data bits
//   parity_kind  1 = odd parity, 0 = even parity
//   rd_ack       one-cycle strobe when the CPU reads rdr
//   rdr          received byte, zero-extended to 16 bits
//   ready        a byte is waiting in rdr
//   parity_err   last completed frame had a parity mismatch
//   frame_err    last completed frame had a stop bit of 0
//   overrun      a frame completed while ready was already set
//   busy         receiver is inside a frame
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 400,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        parity_en,
    input  logic        parity_kind,
    input  logic        rd_ack,
    output logic [15:0] rdr,
    output logic        ready,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // synchroniser and edge-detect flops
    logic rx_m;
    logic rx_s;
    logic rx_d;

    state_t             state,      state_nxt;
    logic [CNT_W-1:0]   cnt,        cnt_nxt;
    logic [2:0]         bit_idx,    bit_idx_nxt;
    logic [7:0]         shift,      shift_nxt;
    logic               p_en_l,     p_en_l_nxt;
    logic               p_kind_l,   p_kind_l_nxt;
    logic               p_bad,      p_bad_nxt;
    logic [15:0]        rdr_nxt;
    logic               ready_nxt;
    logic               parity_err_nxt;
    logic               frame_err_nxt;
    logic               overrun_nxt;
    logic               busy_nxt;

    logic               bit_end;
    logic               half_end;

    assign bit_end  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign half_end = (cnt == CNT_W'(HALF_BIT - 1));

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            p_en_l     <= 1'b0;
            p_kind_l   <= 1'b0;
            p_bad      <= 1'b0;
            rdr        <= '0;
            ready      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_m       <= rxd;
            rx_s       <= rx_m;
            rx_d       <= rx_s;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift      <= shift_nxt;
            p_en_l     <= p_en_l_nxt;
            p_kind_l   <= p_kind_l_nxt;
            p_bad      <= p_bad_nxt;
            rdr        <= rdr_nxt;
            ready      <= ready_nxt;
            parity_err <= parity_err_nxt;
            frame_err  <= frame_err_nxt;
            overrun    <= overrun_nxt;
            busy       <= busy_nxt;
        end
    end

    // next-state and output logic
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bit_idx_nxt    = bit_idx;
        shift_nxt      = shift;
        p_en_l_nxt     = p_en_l;
        p_kind_l_nxt   = p_kind_l;
        p_bad_nxt      = p_bad;
        rdr_nxt        = rdr;
        ready_nxt      = ready;
        parity_err_nxt = parity_err;
        frame_err_nxt  = frame_err;
        overrun_nxt    = overrun;

        // CPU read; a completing frame below overrides ready
        if (rd_ack && ready) begin
            ready_nxt   = 1'b0;
            overrun_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                // only a fresh 1->0 edge starts a frame, a held-low line does not
                if (rx_d && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (half_end) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt    = DATA;
                        bit_idx_nxt  = '0;
                        p_en_l_nxt   = parity_en;
                        p_kind_l_nxt = parity_kind;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_s;
                    bit_idx_nxt        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = p_en_l ? PARITY : STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    p_bad_nxt = ((^{shift, rx_s}) != p_kind_l);
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_nxt        = '0;
                    rdr_nxt        = {8'h00, shift};
                    ready_nxt      = 1'b1;
                    frame_err_nxt  = ~rx_s;
                    parity_err_nxt = p_en_l & p_bad;
                    if (ready && !rd_ack) begin
                        overrun_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx with CLKS_PER_BIT = 16.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic        parity_en;
    logic        parity_kind;
    logic        rd_ack;
    logic [15:0] rdr;
    logic        ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fall_cyc   = 0;
    int rise_cyc   = -1;
    int bfall_cyc  = -1;
    int busy_rises = 0;
    logic ready_q = 1'b0;
    logic busy_q  = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .parity_en  (parity_en),
        .parity_kind(parity_kind),
        .rd_ack     (rd_ack),
        .rdr        (rdr),
        .ready      (ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // edge monitor on the output flags
    always @(negedge clk) begin
        if (ready && !ready_q) rise_cyc = cyc;
        if (!busy && busy_q)   bfall_cyc = cyc;
        if (busy && !busy_q)   busy_rises = busy_rises + 1;
        ready_q = ready;
        busy_q  = busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stopb);
        @(negedge clk);
        rxd = 1'b0;
        fall_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (pen) begin
            rxd = pbit;
            repeat (CPB) @(negedge clk);
        end
        rxd = stopb;
        repeat (CPB) @(negedge clk);
        if (stopb) repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    initial begin
        int lat;
        int rises0;
        logic hit;
        clk = 1'b0;
        rst = 1'b1;
        rxd = 1'b1;
        parity_en = 1'b0;
        parity_kind = 1'b0;
        rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rdr", 32'(rdr), 32'h0);
        check_eq("rst_ready", 32'(ready), 0);
        check_eq("rst_perr", 32'(parity_err), 0);
        check_eq("rst_ferr", 32'(frame_err), 0);
        check_eq("rst_ovr", 32'(overrun), 0);
        check_eq("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // plain frame and latency
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        lat = rise_cyc - fall_cyc;
        check_eq("a5_lat", 32'(lat >= 153 && lat <= 155), 1);
        check_eq("a5_busy_drop", 32'(bfall_cyc), 32'(rise_cyc));
        check_eq("a5_rdr", 32'(rdr), 32'h00A5);
        check_eq("a5_ready", 32'(ready), 1);
        check_eq("a5_perr", 32'(parity_err), 0);
        check_eq("a5_ferr", 32'(frame_err), 0);
        check_eq("a5_ovr", 32'(overrun), 0);
        pulse_ack();
        check_eq("a5_ack_ready", 32'(ready), 0);

        // even parity, good then bad parity bit
        parity_en = 1'b1;
        parity_kind = 1'b0;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        check_eq("ev_ok_perr", 32'(parity_err), 0);
        check_eq("ev_ok_rdr", 32'(rdr), 32'h0003);
        pulse_ack();
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        check_eq("ev_bad_perr", 32'(parity_err), 1);
        check_eq("ev_bad_rdr", 32'(rdr), 32'h0003);
        check_eq("ev_bad_ready", 32'(ready), 1);
        pulse_ack();
        check_eq("ev_bad_hold", 32'(parity_err), 1);
        check_eq("ev_bad_ackrdy", 32'(ready), 0);

        // odd parity; parity_kind flips mid-frame and must be ignored
        parity_kind = 1'b1;
        fork
            send_frame(8'h03, 1'b1, 1'b1, 1'b1);
            begin
                repeat (40) @(negedge clk);
                parity_kind = 1'b0;
            end
        join
        check_eq("odd_perr", 32'(parity_err), 0);
        pulse_ack();
        parity_en = 1'b0;

        // stop bit 0, line held low, no retrigger
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("fe_ferr", 32'(frame_err), 1);
        check_eq("fe_rdr", 32'(rdr), 32'h005A);
        check_eq("fe_ready", 32'(ready), 1);
        rises0 = busy_rises;
        repeat (40 * CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_eq("fe_no_second", 32'(busy_rises), 32'(rises0));
        check_eq("fe_idle_busy", 32'(busy), 0);
        pulse_ack();
        check_eq("fe_hold", 32'(frame_err), 1);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        check_eq("f11_rdr", 32'(rdr), 32'h0011);
        check_eq("f11_ferr", 32'(frame_err), 0);
        check_eq("f11_ovr", 32'(overrun), 0);
        pulse_ack();

        // glitch shorter than half a bit
        rises0 = busy_rises;
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_eq("gl_busy_pulse", 32'(busy_rises - rises0), 1);
        check_eq("gl_busy", 32'(busy), 0);
        check_eq("gl_ready", 32'(ready), 0);

        // overrun then ack
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        check_eq("ov1_ovr", 32'(overrun), 0);
        send_frame(8'h02, 1'b0, 1'b0, 1'b1);
        check_eq("ov2_rdr", 32'(rdr), 32'h0002);
        check_eq("ov2_ovr", 32'(overrun), 1);
        pulse_ack();
        check_eq("ov_ack_ready", 32'(ready), 0);
        check_eq("ov_ack_ovr", 32'(overrun), 0);

        // ack in the exact completion cycle while a byte is pending
        send_frame(8'h07, 1'b0, 1'b0, 1'b1);
        check_eq("f07_rdr", 32'(rdr), 32'h0007);
        hit = 1'b0;
        fork
            send_frame(8'h03, 1'b0, 1'b0, 1'b1);
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 400; i++) begin
                    if (cyc == fall_cyc + 153) begin
                        hit = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                if (hit) begin
                    rd_ack = 1'b1;
                    @(negedge clk);
                    rd_ack = 1'b0;
                end
            end
        join
        check_eq("sim_hit", 32'(hit), 1);
        check_eq("sim_ready", 32'(ready), 1);
        check_eq("sim_ovr", 32'(overrun), 0);
        check_eq("sim_rdr", 32'(rdr), 32'h0003);

        // reset in the middle of DATA
        fork
            send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (4 * CPB) @(negedge clk);
                rst = 1'b1;
                #1;
                check_eq("mr_busy", 32'(busy), 0);
                check_eq("mr_ready", 32'(ready), 0);
                check_eq("mr_rdr", 32'(rdr), 32'h0);
                check_eq("mr_flags", 32'({parity_err, frame_err, overrun}), 0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        check_eq("mr_no_frame", 32'(ready), 0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check_eq("f3c_rdr", 32'(rdr), 32'h003C);
        check_eq("f3c_ready", 32'(ready), 1);
        check_eq("f3c_ferr", 32'(frame_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the LC3 serial path; the receive end of the 8-bit, LSB-first, optional-parity link driven by the LC3 transmitter.
- Rebuilds frames from the serial line and checks the start bit, parity and stop bit.
- Presents the received byte zero-extended to 16 bits, with ready, error and overrun status, for the LC3 memory-mapped receive data and status registers.
- The CPU consumes each byte with a one-cycle read acknowledge.

Parameters:
- CLKS_PER_BIT, 400: clk cycles per bit (400 gives 9600 bps at the system clock). Must be at least 8.
- HALF_BIT, CLKS_PER_BIT/2: sample offset from the start edge to the middle of the start bit.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- rxd, input, 1: serial line, asynchronous; idle level is 1.
- parity_en, input, 1: 1 means a parity bit follows the data bits.
- parity_kind, input, 1: 1 means odd parity, 0 means even parity.
- rd_ack, input, 1: one-cycle strobe when the CPU reads rdr.
- rdr, output, 16: received byte, {8'h00, data[7:0]}.
- ready, output, 1: a byte is waiting in rdr.
- parity_err, output, 1: the last completed frame had a parity mismatch.
- frame_err, output, 1: the last completed frame had its stop bit equal to 0.
- overrun, output, 1: a frame completed while ready was already 1.
- busy, output, 1: the state machine is not in IDLE.

Behaviour:
- Reset values:
  - rdr = 16'h0000; ready, parity_err, frame_err, overrun and busy = 0.
  - The rxd synchroniser flops reset to 1; state = IDLE; all counters = 0.
  - Reset in the middle of a frame discards the partial frame, and no flags are set.
- Input path: rxd passes through 2 synchroniser flops, giving rx_s. A third flop, rx_d, is used for edge detection.
- State machine: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - A falling edge on rx_s (rx_d=1, rx_s=0) moves to START and clears the cycle counter.
  - A line held low (break, or after a frame error) does not retrigger. A new 1-to-0 edge is required.
- START:
  - When the cycle counter reaches HALF_BIT-1, rx_s is sampled.
  - If rx_s=0: go to DATA, clear the cycle counter and bit index, and latch parity_en and parity_kind for the whole frame.
  - If rx_s=1: the edge was a glitch; return to IDLE with no flags changed.
- DATA:
  - Each time the cycle counter reaches CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first), increment bit_idx and clear the cycle counter.
  - After the 8th sample, go to PARITY if the latched parity_en=1, otherwise to STOP.
- PARITY: one bit time later, sample the parity bit.
  - Mismatch is defined as: ^{data, pbit} != latched parity_kind. This means even parity requires an even count of ones and odd parity an odd count.
- STOP: one bit time later, sample the stop bit. In the same edge:
  - rdr is loaded with {8'h00, shift}, and ready is set to 1.
  - frame_err is set to ~stop_bit.
  - parity_err is set to the mismatch result, or 0 when parity is disabled.
  - overrun is set to 1 if ready was already 1 and rd_ack is not asserted in that cycle. Otherwise overrun keeps its value.
  - The state returns to IDLE.
- Error frames: a frame with frame_err or parity_err is still loaded into rdr and still sets ready.
- rd_ack:
  - Clears ready and overrun on the next edge. parity_err and frame_err hold until the next frame completes.
  - If rd_ack and frame completion occur in the same cycle, completion wins: ready=1 and overrun=0.
  - rd_ack while ready=0 has no effect.
- Latency (no parity): ready rises 2 + HALF_BIT + 9*CLKS_PER_BIT clk cycles after the falling edge on rxd, plus or minus 1. With parity, add CLKS_PER_BIT.
- busy is 1 in START, DATA, PARITY and STOP.
- The parity_en and parity_kind inputs may change mid-frame without affecting the current frame.

Test Plan:
- CLKS_PER_BIT=16, no parity; send 0xA5 with stop bit 1 -> ready rises 154 plus or minus 1 cycles after the start edge; rdr=16'h00A5; parity_err=0; frame_err=0; overrun=0; busy drops in the same cycle.
- Parity enabled, even:
  - Send 0x03 with parity bit 0 -> parity_err=0.
  - Resend with parity bit 1 -> parity_err=1, rdr=16'h0003, ready=1.
  - Repeat with odd parity and parity bit 1 -> parity_err=0.
- Send 0x5A with stop bit 0, then hold rxd low for 40 bit times, then release -> frame_err=1, rdr=16'h005A, no second frame. The next proper frame of 0x11 -> rdr=16'h0011, frame_err=0.
- Glitch: pull rxd low for 4 cycles (fewer than HALF_BIT), then high -> busy pulses, returns to IDLE, ready stays 0.
- Overrun and ack:
  - Receive 0x01 without rd_ack, then 0x02 -> rdr=16'h0002, overrun=1.
  - Pulse rd_ack -> ready=0, overrun=0.
  - Then pulse rd_ack in the exact completion cycle of 0x03 -> ready=1, overrun=0.
- Assert rst in the middle of DATA of 0xFF -> all outputs return to their reset values immediately. The following 0x3C frame is received correctly.
